// File: rtl/alu_pkg.sv
// Shared ALU decode constants: ALU_Control codes, RV opcodes, funct7 values.
package alu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_MUL = 4'b0010,
      ALU_DIV = 4'b0011,
      ALU_AND = 4'b0100,
      ALU_OR  = 4'b0101,
      ALU_XOR = 4'b0110,
      ALU_NOT = 4'b0111,
      ALU_SLL = 4'b1000,
      ALU_SRL = 4'b1001,
      ALU_SRA = 4'b1010
   } alu_op_e;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

endpackage

// File: rtl/alu_dec.sv
// Combinational RV32I/M ALU instruction decoder.
// Also used by the hazard unit, so it carries no state.
module alu_dec
   import alu_pkg::*;
(
   input  logic [31:0] instr,
   output alu_op_e     alu_op,
   output logic        use_imm,
   output logic        is_shift,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       unused_fields;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign unused_fields = ^{instr[19:15], instr[11:7]};

   always_comb begin
      alu_op   = ALU_ADD;
      use_imm  = 1'b0;
      is_shift = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OP_R: begin
            case ({f7, f3})
               {F7_BASE, 3'b000}:   alu_op = ALU_ADD;
               {F7_BASE, 3'b001}:   alu_op = ALU_SLL;
               {F7_BASE, 3'b100}:   alu_op = ALU_XOR;
               {F7_BASE, 3'b101}:   alu_op = ALU_SRL;
               {F7_BASE, 3'b110}:   alu_op = ALU_OR;
               {F7_BASE, 3'b111}:   alu_op = ALU_AND;
               {F7_ALT, 3'b000}:    alu_op = ALU_SUB;
               {F7_ALT, 3'b101}:    alu_op = ALU_SRA;
               {F7_MULDIV, 3'b000}: alu_op = ALU_MUL;
               {F7_MULDIV, 3'b100}: alu_op = ALU_DIV;
               default:             illegal = 1'b1;
            endcase
         end
         OP_I: begin
            use_imm = 1'b1;
            case (f3)
               3'b000: alu_op = ALU_ADD;
               3'b100: alu_op = (instr[31:20] == 12'hFFF) ? ALU_NOT : ALU_XOR;
               3'b110: alu_op = ALU_OR;
               3'b111: alu_op = ALU_AND;
               3'b001: begin
                  is_shift = 1'b1;
                  if (f7 == F7_BASE) alu_op = ALU_SLL;
                  else               illegal = 1'b1;
               end
               3'b101: begin
                  is_shift = 1'b1;
                  if (f7 == F7_BASE)     alu_op = ALU_SRL;
                  else if (f7 == F7_ALT) alu_op = ALU_SRA;
                  else                   illegal = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
      // Illegal packets still issue, but as a harmless ADD of zeros.
      if (illegal) begin
         alu_op   = ALU_ADD;
         use_imm  = 1'b0;
         is_shift = 1'b0;
      end
   end

endmodule

// File: rtl/alu_op_issue.sv
// ALU operand issue stage: decode, registered output, 2-entry skid buffer,
// and issued/illegal event counters.
module alu_op_issue
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  A,
   output logic [XLEN-1:0]  B,
   output logic [3:0]       ALU_Control,
   output logic [4:0]       rd,
   output logic             illegal,
   output logic [CNT_W-1:0] issued_cnt,
   output logic [CNT_W-1:0] illegal_cnt
);

   alu_op_e dec_op;
   logic    dec_imm;
   logic    dec_shift;
   logic    dec_ill;

   alu_dec u_dec (
      .instr    (instr),
      .alu_op   (dec_op),
      .use_imm  (dec_imm),
      .is_shift (dec_shift),
      .illegal  (dec_ill)
   );

   logic [XLEN-1:0] imm_x;
   logic [XLEN-1:0] shamt_x;
   logic [XLEN-1:0] new_a;
   logic [XLEN-1:0] new_b;

   assign imm_x   = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign shamt_x = {{(XLEN-5){1'b0}}, instr[24:20]};

   always_comb begin
      new_a = '0;
      new_b = '0;
      if (!dec_ill) begin
         new_a = rs1_data;
         if (dec_shift)    new_b = shamt_x;
         else if (dec_imm) new_b = imm_x;
         else              new_b = rs2_data;
      end
   end

   logic            sk_full;
   logic [XLEN-1:0] sk_a;
   logic [XLEN-1:0] sk_b;
   logic [3:0]      sk_op;
   logic [4:0]      sk_rd;
   logic            sk_ill;

   logic in_fire;
   logic out_fire;
   logic out_free;

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   assign out_free = out_fire || !out_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid   <= 1'b0;
         in_ready    <= 1'b1;
         A           <= '0;
         B           <= '0;
         ALU_Control <= ALU_ADD;
         rd          <= '0;
         illegal     <= 1'b0;
         sk_full     <= 1'b0;
         sk_a        <= '0;
         sk_b        <= '0;
         sk_op       <= ALU_ADD;
         sk_rd       <= '0;
         sk_ill      <= 1'b0;
         issued_cnt  <= '0;
         illegal_cnt <= '0;
      end else begin
         if (out_free) begin
            // in_ready is low whenever the skid is full, so no new packet
            // can compete with the skid entry for the output register.
            if (sk_full) begin
               out_valid   <= 1'b1;
               A           <= sk_a;
               B           <= sk_b;
               ALU_Control <= sk_op;
               rd          <= sk_rd;
               illegal     <= sk_ill;
               sk_full     <= 1'b0;
               in_ready    <= 1'b1;
            end else if (in_fire) begin
               out_valid   <= 1'b1;
               A           <= new_a;
               B           <= new_b;
               ALU_Control <= dec_op;
               rd          <= instr[11:7];
               illegal     <= dec_ill;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (in_fire) begin
            sk_full  <= 1'b1;
            in_ready <= 1'b0;
            sk_a     <= new_a;
            sk_b     <= new_b;
            sk_op    <= dec_op;
            sk_rd    <= instr[11:7];
            sk_ill   <= dec_ill;
         end
         if (out_fire) begin
            issued_cnt <= issued_cnt + 1'b1;
            if (illegal) illegal_cnt <= illegal_cnt + 1'b1;
         end
      end
   end

endmodule
